if_prefetch_queue: RTL
======================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation 5-stage core: replaces the
//  single-cycle inst_sram path with an SRAM-like req/addr_ok/data_ok handshake.
//  Issues sequential fetches with up to MAX_OUTST requests in flight and buffers returned
//  {pc,inst} pairs in a DEPTH-entry queue feeding ID through valid/ready.
//  On branch redirect it flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC   32'hbfc0_0000  first fetch address after reset
//  DEPTH      4              queue entries (power of 2, >=2)
//  MAX_OUTST  2              max accepted-but-unreturned requests (1..DEPTH)
//  AW         32             address / PC width
//  DW         32             instruction width
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous, active-low reset (0 = reset)
//  br_e          in   1        redirect strobe from ID (one cycle)
//  br_addr       in   AW       redirect target
//  inst_req      out  1        fetch request
//  inst_addr     out  AW       fetch address, word aligned
//  inst_addr_ok  in   1        request accepted this cycle
//  inst_data_ok  in   1        response valid this cycle (in order)
//  inst_rdata    in   DW       response data
//  id_valid      out  1        queue head valid
//  id_ready      in   1        ID accepts head (stall = 0)
//  id_pc         out  AW       head PC
//  id_inst       out  DW       head instruction
// BEHAVIOUR
//  Reset: inst_req=0, inst_addr=RESET_PC, id_valid=0, queue empty, counters 0.
//  Fetch PC: fetch_pc<=RESET_PC; +4 on each inst_req&inst_addr_ok; <=br_addr on br_e.
//  Credit: inst_req=1 iff count+outst < DEPTH and outst < MAX_OUTST, and no discard
//   pending that exceeds remaining credit. Once inst_req=1 and addr_ok=0, hold inst_req/addr
//   stable until accepted; a redirect does not withdraw it.
//  outst: +1 on req&addr_ok, -1 on data_ok; both same cycle -> unchanged.
//  Each accepted request pushes its PC into a MAX_OUTST-deep in-flight PC FIFO; data_ok pops it.
//  data_ok with discard==0: push {pc,rdata}; id_valid visible next cycle (latency 1).
//  data_ok with discard>0: drop response, discard-=1.
//  br_e: queue emptied same edge; discard<=outst after this cycle's accept/return;
//   fetch_pc<=br_addr. A request held pending (addr_ok=0) at br_e is counted toward
//   discard when accepted and does not advance fetch_pc.
//  br_e with id_ready&id_valid same cycle: the pop completes (ID consumed head), then flush.
//  br_e and data_ok same cycle: response discarded.
//  Pop: id_valid&id_ready -> head advances; push and pop together with full queue is legal.
//  Full queue never overflows: credit rule guarantees space for every outstanding return.
//  Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
//  rst asserted mid-operation: all state to reset values immediately; later data_ok for
//   pre-reset requests is not expected from the bus (bus is reset together).
//  Misaligned br_addr: low 2 bits forced to 0 on inst_addr.
// STRUCTURE
//  defines.vh: IF_TO_ID_WD (=AW+DW), BR_WD (=AW+1), RESET_PC default, bus packing order
//   {br_e,br_addr} and {id_pc,id_inst}.
//  Sub-module: fetch_fifo (generic WIDTH/DEPTH sync FIFO, flush input), instanced twice:
//   data queue (AW+DW x DEPTH) and in-flight PC FIFO (AW x MAX_OUTST).
//  Top holds fetch_pc, outst, discard counters and credit logic.
// TESTING
//  Reset release, addr_ok=1, data_ok 1 cycle later, id_ready=1 -> id_pc 0xbfc00000,
//   0xbfc00004, ... one per cycle after 2-cycle fill.
//  id_ready=0 with DEPTH=4 -> exactly 4 entries then inst_req drops; no lost/duplicate PC.
//  2 requests in flight, br_e to 0x80001000 -> both responses dropped, next id_pc 0x80001000.
//  addr_ok held low 3 cycles with br_e in cycle 2 -> inst_addr stable; that reply discarded.
//  br_e coincident with data_ok and id pop -> popped head consumed, reply dropped, queue empty.
//  rst low mid-burst -> inst_req=0, id_valid=0 next edge; restart fetches 0xbfc00000.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared defaults and sizing helpers for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

   localparam int unsigned AW_DEF        = 32;
   localparam int unsigned DW_DEF        = 32;
   localparam int unsigned DEPTH_DEF     = 4;
   localparam int unsigned MAX_OUTST_DEF = 2;
   localparam logic [31:0] RESET_PC_DEF  = 32'hbfc0_0000;

   // Occupancy counter width able to hold 0..entries inclusive.
   function automatic int unsigned cnt_width(input int unsigned entries);
      return $clog2(entries) + 1;
   endfunction

endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// Generic synchronous FIFO with flush; used for the {pc,inst} queue and the in-flight PC list.
module fetch_fifo
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        push,
   input  logic [WIDTH-1:0]            wdata,
   input  logic                        pop,
   output logic [WIDTH-1:0]            rdata,
   output logic [cnt_width(DEPTH)-1:0] count
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Wrap explicitly so non-power-of-two depths work for the in-flight list.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch over an addr_ok/data_ok bus,
// buffering {pc,inst} pairs for ID and discarding stale replies after a redirect.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned   AW        = AW_DEF,
   parameter int unsigned   DW        = DW_DEF,
   parameter logic [AW-1:0] RESET_PC  = AW'(RESET_PC_DEF),
   parameter int unsigned   DEPTH     = DEPTH_DEF,
   parameter int unsigned   MAX_OUTST = MAX_OUTST_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          br_e,
   input  logic [AW-1:0] br_addr,
   output logic          inst_req,
   output logic [AW-1:0] inst_addr,
   input  logic          inst_addr_ok,
   input  logic          inst_data_ok,
   input  logic [DW-1:0] inst_rdata,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [AW-1:0] id_pc,
   output logic [DW-1:0] id_inst
);
   localparam int unsigned   CW         = cnt_width(DEPTH);
   localparam int unsigned   OW         = cnt_width(MAX_OUTST);
   localparam int unsigned   SW         = CW + 1;
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

   logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             req_q, req_d;
   logic             stale_q, stale_d;
   logic [OW-1:0]    discard_q, discard_d;
   logic [OW-1:0]    outst, outst_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic             acc, ret, drop, push, pop, credit;
   logic [AW-1:0]    flight_pc;
   logic [AW+DW-1:0] head;

   assign acc       = req_q & inst_addr_ok;
   assign ret       = inst_data_ok;
   assign drop      = ret & (br_e | (discard_q != '0));
   assign push      = ret & ~drop;
   assign pop       = id_valid & id_ready;
   assign outst_nxt = outst + OW'(acc) - OW'(ret);
   assign count_nxt = br_e ? '0 : count + CW'(push) - CW'(pop);

   // Every outstanding reply must have a queue slot waiting for it.
   assign credit = ((SW'(count_nxt) + SW'(outst_nxt)) < SW'(DEPTH)) &&
                   (outst_nxt < OW'(MAX_OUTST));

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      stale_d    = stale_q;
      req_d      = req_q;
      addr_d     = addr_q;
      if (acc && !stale_q) fetch_pc_d = fetch_pc_q + AW'(4);
      if (ret && (discard_q != '0)) discard_d = discard_q - OW'(1);
      // A request held across a redirect is stale: its reply joins the discard count.
      if (acc && stale_q) begin
         discard_d = discard_d + OW'(1);
         stale_d   = 1'b0;
      end
      if (br_e) begin
         fetch_pc_d = br_addr & ALIGN_MASK;
         discard_d  = outst_nxt;
         stale_d    = req_q & ~inst_addr_ok;
      end
      if (req_q && !inst_addr_ok) begin
         req_d  = 1'b1;
         addr_d = addr_q;
      end else begin
         req_d  = credit;
         addr_d = fetch_pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         stale_q    <= 1'b0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         stale_q    <= stale_d;
         discard_q  <= discard_d;
      end
   end

   // In-flight PC list; its occupancy is the outstanding-request count.
   fetch_fifo #(.WIDTH(AW), .DEPTH(MAX_OUTST)) u_flight (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (acc),
      .wdata (addr_q),
      .pop   (ret),
      .rdata (flight_pc),
      .count (outst)
   );

   fetch_fifo #(.WIDTH(AW + DW), .DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (br_e),
      .push  (push),
      .wdata ({flight_pc, inst_rdata}),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   assign inst_req  = req_q;
   assign inst_addr = addr_q;
   assign id_valid  = (count != '0);
   assign id_pc     = head[AW+DW-1:DW];
   assign id_inst   = head[DW-1:0];

endmodule
